// File: rtl/instr_mem_fetch_if.sv
// Fetch/load bus between the fetch stage (master) and the instruction memory (slave).
// Carries the fetch handshake, the program-load write port and the busy/error status.
interface instr_mem_fetch_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_stall;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;
    logic              busy;

    modport master (
        output fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr, wr_data,
        input  fetch_ready, fetch_valid, fetch_data, wr_err, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_stall, wr_en, wr_addr, wr_data,
        output fetch_ready, fetch_valid, fetch_data, wr_err, busy
    );
endinterface

// File: rtl/instr_mem_fetch.sv
// Instruction memory with a 1-cycle fetch port, a program-load write port,
// and a post-reset sequencer that clears every word to INIT_WORD.
module instr_mem_fetch #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       ADDR_W    = 4,
    parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
    input logic              clk,
    input logic              rst,
    instr_mem_fetch_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR, READY} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wr_err_q, wr_err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              accept;

    assign bus.fetch_ready = (state_q == READY) && !bus.fetch_stall;
    assign accept          = bus.fetch_req && bus.fetch_ready;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_data  = data_q;
    assign bus.wr_err      = wr_err_q;
    assign bus.busy        = busy_q;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        data_d    = data_q;
        wr_err_d  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = INIT_WORD;
        case (state_q)
            CLEAR: begin
                // Load-port writes are dropped while clearing and flagged next cycle.
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                wr_err_d  = bus.wr_en;
                valid_d   = 1'b0;
                if (clr_ptr_q == '1) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                mem_we    = bus.wr_en;
                mem_waddr = bus.wr_addr;
                mem_wdata = bus.wr_data;
                if (!bus.fetch_stall) begin
                    valid_d = accept;
                    if (accept) begin
                        // Write-first: a same-cycle write to the fetched word is forwarded.
                        data_d = (bus.wr_en && (bus.wr_addr == bus.fetch_addr))
                                 ? bus.wr_data : mem_q[bus.fetch_addr];
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= INIT_WORD;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the memory.
module tb_instr_mem_fetch;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    instr_mem_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_mem_fetch #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_WORD(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: memory image, clear cycles still to run, and expected outputs.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                clr_left;
    logic              ref_valid;
    logic [DATA_W-1:0] ref_data;
    logic              ref_err;

    task automatic cycle();
        logic              r, we, rq, st;
        logic [ADDR_W-1:0] fa, wa;
        logic [DATA_W-1:0] wd;
        r  = rst;
        we = bus.wr_en;
        rq = bus.fetch_req;
        st = bus.fetch_stall;
        fa = bus.fetch_addr;
        wa = bus.wr_addr;
        wd = bus.wr_data;
        @(posedge clk);
        if (r) begin
            clr_left  = DEPTH;
            ref_valid = 1'b0;
            ref_data  = 16'h0000;
            ref_err   = 1'b0;
        end else if (clr_left > 0) begin
            ref_mem[DEPTH - clr_left] = 16'h0000;
            ref_err   = we;
            ref_valid = 1'b0;
            clr_left  = clr_left - 1;
        end else begin
            ref_err = 1'b0;
            if (rq && !st) begin
                ref_data  = (we && wa == fa) ? wd : ref_mem[fa];
                ref_valid = 1'b1;
            end else if (!st) begin
                ref_valid = 1'b0;
            end
            if (we) ref_mem[wa] = wd;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_req   = 1'b0;
        bus.fetch_addr  = '0;
        bus.fetch_stall = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
    endtask

    task automatic test_reset();
        int cnt;
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.fetch_valid !== 1'b0 || bus.wr_err !== 1'b0 ||
            bus.fetch_ready !== 1'b0 || bus.fetch_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b err=%b ready=%b data=%h, required 1 0 0 0 0000",
                     bus.busy, bus.fetch_valid, bus.wr_err, bus.fetch_ready, bus.fetch_data);
        end
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (bus.busy !== 1'b1) break;
            cnt++;
        end
        n_tests++;
        if (cnt != 16 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_length: busy cycles=%0d busy=%b, required 16 then 0", cnt, bus.busy);
        end
        for (int a = 0; a < 16; a++) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = ADDR_W'(a);
            cycle();
            n_tests++;
            if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 16'h0000) begin
                n_fail++;
                $display("FAIL cleared_word[%0d]: valid=%b data=%h, required 1 0000",
                         a, bus.fetch_valid, bus.fetch_data);
            end
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_back_to_back();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h4120;
        cycle();
        bus.wr_addr = 4'd7; bus.wr_data = 16'h6120;
        cycle();
        bus.wr_en = 1'b0;
        bus.fetch_req = 1'b1; bus.fetch_addr = 4'd3;
        cycle();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 16'h4120) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b data=%h, required 1 4120", bus.fetch_valid, bus.fetch_data);
        end
        bus.fetch_addr = 4'd7;
        cycle();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 16'h6120) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b data=%h, required 1 6120", bus.fetch_valid, bus.fetch_data);
        end
        idle_inputs();
        cycle();
        n_tests++;
        if (bus.fetch_valid !== 1'b0 || bus.fetch_data !== 16'h6120) begin
            n_fail++;
            $display("FAIL idle_hold: valid=%b data=%h, required 0 6120", bus.fetch_valid, bus.fetch_data);
        end
    endtask

    task automatic test_bypass();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hBEEF;
        bus.fetch_req = 1'b1; bus.fetch_addr = 4'd5;
        cycle();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass: valid=%b data=%h, required 1 beef", bus.fetch_valid, bus.fetch_data);
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_stall();
        bus.fetch_req = 1'b1; bus.fetch_addr = 4'd3;
        cycle();
        n_tests++;
        if (bus.fetch_data !== 16'h4120) begin
            n_fail++;
            $display("FAIL stall_pre: data=%h, required 4120", bus.fetch_data);
        end
        bus.fetch_stall = 1'b1; bus.fetch_addr = 4'd7;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (bus.fetch_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: ready=%b, required 0", i, bus.fetch_ready);
            end
            cycle();
            bus.wr_en = 1'b0;
            n_tests++;
            if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 16'h4120) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h, required 1 4120",
                         i, bus.fetch_valid, bus.fetch_data);
            end
        end
        bus.fetch_stall = 1'b0;
        #1;
        n_tests++;
        if (bus.fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL unstall_ready: ready=%b, required 1", bus.fetch_ready);
        end
        cycle();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 16'h6120) begin
            n_fail++;
            $display("FAIL unstall_fetch: valid=%b data=%h, required 1 6120", bus.fetch_valid, bus.fetch_data);
        end
        bus.fetch_addr = 4'd3;
        cycle();
        n_tests++;
        if (bus.fetch_data !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL stall_write: data=%h, required aaaa", bus.fetch_data);
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_clear_write();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 16'h5555;
        cycle();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd6; bus.wr_data = 16'hFFFF;
        cycle();
        bus.wr_en = 1'b0;
        n_tests++;
        if (bus.wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_pulse: err=%b, required 1", bus.wr_err);
        end
        cycle();
        n_tests++;
        if (bus.wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_err_single: err=%b, required 0", bus.wr_err);
        end
        for (int i = 0; i < 40 && bus.busy === 1'b1; i++) cycle();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_timeout: busy=%b, required 0", bus.busy);
        end
        bus.fetch_req = 1'b1; bus.fetch_addr = 4'd6;
        cycle();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL dropped_write: valid=%b data=%h, required 1 0000", bus.fetch_valid, bus.fetch_data);
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h1234;
        cycle();
        bus.wr_en = 1'b0; bus.fetch_req = 1'b1; bus.fetch_addr = 4'd2;
        cycle();
        n_tests++;
        if (bus.fetch_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL pre_reset_word: data=%h, required 1234", bus.fetch_data);
        end
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cnt = (bus.busy === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (bus.busy !== 1'b1) break;
            cnt++;
        end
        n_tests++;
        if (cnt != 16 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clear: busy cycles=%0d busy=%b, required 16 then 0", cnt, bus.busy);
        end
        bus.fetch_req = 1'b1; bus.fetch_addr = 4'd2;
        cycle();
        n_tests++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL recleared_word: valid=%b data=%h, required 1 0000", bus.fetch_valid, bus.fetch_data);
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 149) == 0);
            bus.fetch_req   = $urandom_range(0, 1) == 1;
            bus.fetch_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.fetch_stall = ($urandom_range(0, 3) == 0);
            bus.wr_en       = ($urandom_range(0, 2) == 0);
            bus.wr_addr     = ($urandom_range(0, 1) == 1) ? bus.fetch_addr
                                                          : ADDR_W'($urandom_range(0, DEPTH - 1));
            bus.wr_data     = DATA_W'($urandom);
            #1;
            n_tests++;
            if (bus.fetch_ready !== (clr_left == 0 && !bus.fetch_stall)) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: ready=%b, required %b",
                         i, bus.fetch_ready, (clr_left == 0 && !bus.fetch_stall));
            end
            cycle();
            n_tests++;
            if (bus.busy !== (clr_left > 0) || bus.fetch_valid !== ref_valid ||
                bus.fetch_data !== ref_data || bus.wr_err !== ref_err) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: busy=%b valid=%b data=%h err=%b, required %b %b %h %b",
                         i, bus.busy, bus.fetch_valid, bus.fetch_data, bus.wr_err,
                         (clr_left > 0), ref_valid, ref_data, ref_err);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        clr_left  = DEPTH;
        ref_valid = 1'b0;
        ref_data  = '0;
        ref_err   = 1'b0;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_bypass();
        test_stall();
        test_clear_write();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
